// File: rtl/if_pkg.sv
// ---------------------------------------------------------------------------
// if_pkg: shared definitions for the instruction-fetch stage.
//   INSTR_W        instruction word width
//   NOP_INSTR      encoding placed in IF/ID for a bubble
//   fetch_state_e  fetch controller states
//     S_REQ   request outstanding at PC
//     S_HOLD  fetched word buffered, IF/ID stalled, no request
//     S_DROP  wrong-path request outstanding, its response is discarded
// ---------------------------------------------------------------------------
package if_pkg;

    localparam int unsigned INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_DROP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/ifid_pipe_reg.sv
// ---------------------------------------------------------------------------
// ifid_pipe_reg: IF/ID pipeline register (pc4, instr, valid).
//   clk_i     clock, rising edge
//   rst_i     asynchronous active-high reset, clears all fields
//   flush     squash to bubble; pc4 is left untouched (highest priority)
//   write     load pc4_in / instr_in and mark valid
//   bubble    insert a bubble (instr NOP, valid 0) when nothing is loaded
//   pc4_in    PC+4 of the incoming instruction
//   instr_in  incoming instruction word
//   pc4       registered PC+4
//   instr     registered instruction (NOP when bubble)
//   valid     register holds a real instruction
// ---------------------------------------------------------------------------
module ifid_pipe_reg
    import if_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush,
    input  logic               write,
    input  logic               bubble,
    input  logic [31:0]        pc4_in,
    input  logic [INSTR_W-1:0] instr_in,
    output logic [31:0]        pc4,
    output logic [INSTR_W-1:0] instr,
    output logic               valid
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc4   <= 32'h0;
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (flush) begin
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (write) begin
            pc4   <= pc4_in;
            instr <= instr_in;
            valid <= 1'b1;
        end else if (bubble) begin
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage: instruction-fetch stage of the 5-stage MIPS pipeline.
// Owns the PC, drives a single-outstanding req/ack port to instruction
// memory, buffers one fetched word while IF/ID is stalled and feeds IF/ID.
//   RESET_PC           PC value loaded on reset
//   clk_i, rst_i       clock; asynchronous active-high reset
//   PCWrite            hazard unit: permits PC update
//   ifid_Write         hazard unit: permits IF/ID load
//   if_flush           hazard unit: squash IF/ID to a bubble
//   mem_branch_taken   MEM-stage branch resolved taken
//   mem_branch_target  redirect address
//   imem_req/addr      fetch request and address
//   imem_ack/rdata     memory response for the outstanding request
//   ifid_pc4/instr/valid  IF/ID register contents
//   if_busy            request outstanding with no data yet
// ---------------------------------------------------------------------------
module if_fetch_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               PCWrite,
    input  logic               ifid_Write,
    input  logic               if_flush,
    input  logic               mem_branch_taken,
    input  logic [31:0]        mem_branch_target,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [31:0]        ifid_pc4,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic               ifid_valid,
    output logic               if_busy
);

    fetch_state_e       state_q;
    logic [31:0]        pc_q;
    logic [31:0]        drop_addr_q;
    logic [INSTR_W-1:0] buf_q;

    logic               avail;
    logic               load;
    logic               redirect;
    logic               bubble;
    logic [INSTR_W-1:0] src_instr;
    logic [31:0]        pc_plus4;

    always_comb begin
        pc_plus4  = pc_q + 32'd4;
        avail     = ((state_q == S_REQ) && imem_ack) || (state_q == S_HOLD);
        src_instr = (state_q == S_HOLD) ? buf_q : imem_rdata;
        load      = avail && ifid_Write && !if_flush && !mem_branch_taken;
        // A taken branch is only acted on when the PC may be written.
        redirect  = mem_branch_taken && PCWrite;
        bubble    = ifid_Write && !avail;
    end

    // Request is gated by reset so nothing is issued while rst_i is held.
    assign imem_req  = !rst_i && ((state_q == S_REQ) || (state_q == S_DROP));
    // While dropping, keep presenting the squashed address until its ack.
    assign imem_addr = (state_q == S_DROP) ? drop_addr_q : pc_q;
    assign if_busy   = imem_req && !imem_ack;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            drop_addr_q <= RESET_PC;
            buf_q       <= NOP_INSTR;
        end else begin
            if (PCWrite) begin
                if (mem_branch_taken) begin
                    pc_q <= mem_branch_target;
                end else if (load) begin
                    pc_q <= pc_plus4;
                end
            end

            unique case (state_q)
                S_REQ: begin
                    if (redirect) begin
                        // Without an ack the old request is still in flight;
                        // its response must be swallowed.
                        if (!imem_ack) begin
                            state_q     <= S_DROP;
                            drop_addr_q <= pc_q;
                        end
                    end else if (imem_ack && !load) begin
                        state_q <= S_HOLD;
                        buf_q   <= imem_rdata;
                    end
                end
                S_HOLD: begin
                    if (redirect) begin
                        state_q <= S_REQ;
                        buf_q   <= NOP_INSTR;
                    end else if (load) begin
                        state_q <= S_REQ;
                    end
                end
                S_DROP: begin
                    // A further redirect only moves the PC; the stale request
                    // is still outstanding, so stay here until its ack.
                    if (imem_ack) begin
                        state_q <= S_REQ;
                    end
                end
                default: begin
                    state_q <= S_REQ;
                end
            endcase
        end
    end

    ifid_pipe_reg u_ifid_pipe_reg (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .flush    (if_flush),
        .write    (load),
        .bubble   (bubble),
        .pc4_in   (pc_plus4),
        .instr_in (src_instr),
        .pc4      (ifid_pc4),
        .instr    (ifid_instr),
        .valid    (ifid_valid)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_stage: directed scenarios plus a randomized run against a
// transaction-level reference model of the fetch stage.
// ---------------------------------------------------------------------------
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        PCWrite = 1'b0;
    logic        ifid_Write = 1'b0;
    logic        if_flush = 1'b0;
    logic        mem_branch_taken = 1'b0;
    logic [31:0] mem_branch_target = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] ifid_pc4;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic        if_busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: architectural PC, at most one buffered word, and
    // whether the outstanding request belongs to a squashed path.
    logic [31:0] m_pc, m_hold_word, m_drop_addr, m_pc4, m_instr;
    bit          m_hold, m_drop, m_valid;

    // Variable-latency memory used by the randomized run.
    bit          mem_pend;
    int unsigned mem_lat;

    if_fetch_stage #(
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .PCWrite           (PCWrite),
        .ifid_Write        (ifid_Write),
        .if_flush          (if_flush),
        .mem_branch_taken  (mem_branch_taken),
        .mem_branch_target (mem_branch_target),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_ack          (imem_ack),
        .imem_rdata        (imem_rdata),
        .ifid_pc4          (ifid_pc4),
        .ifid_instr        (ifid_instr),
        .ifid_valid        (ifid_valid),
        .if_busy           (if_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h8BAD_0000;
    endfunction

    task automatic model_reset;
        m_pc = 32'h0; m_hold = 0; m_drop = 0; m_hold_word = 32'h0;
        m_drop_addr = 32'h0; m_pc4 = 32'h0; m_instr = 32'h0; m_valid = 0;
    endtask

    // Advance the model by one cycle using the inputs currently applied.
    task automatic model_step;
        bit          have, take, redir;
        logic [31:0] word;
        have  = m_hold || (!m_drop && imem_ack);
        word  = m_hold ? m_hold_word : mem_word(m_pc);
        take  = have && ifid_Write && !if_flush && !mem_branch_taken;
        redir = mem_branch_taken && PCWrite;
        if (if_flush) begin
            m_instr = 32'h0; m_valid = 0;
        end else if (take) begin
            m_instr = word; m_pc4 = m_pc + 32'd4; m_valid = 1;
        end else if (ifid_Write && !have) begin
            m_instr = 32'h0; m_valid = 0;
        end
        if (m_drop) begin
            if (imem_ack) m_drop = 0;
        end else if (redir) begin
            if (!m_hold && !imem_ack) begin
                m_drop = 1; m_drop_addr = m_pc;
            end
            m_hold = 0;
        end else if (m_hold) begin
            if (take) m_hold = 0;
        end else if (imem_ack && !take) begin
            m_hold = 1; m_hold_word = word;
        end
        if (PCWrite) begin
            if (mem_branch_taken) m_pc = mem_branch_target;
            else if (take) m_pc = m_pc + 32'd4;
        end
    endtask

    // Called just after a rising edge; leaves combinational outputs settled.
    task automatic drive(input logic pcw, input logic ifw, input logic fl, input logic bt,
                         input logic [31:0] tgt, input logic ack);
        PCWrite = pcw; ifid_Write = ifw; if_flush = fl;
        mem_branch_taken = bt; mem_branch_target = tgt;
        imem_ack = ack;
        imem_rdata = ack ? mem_word(imem_addr) : $urandom();
        #2;
    endtask

    task automatic advance;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        PCWrite = 0; ifid_Write = 0; if_flush = 0; mem_branch_taken = 0; imem_ack = 0;
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset;
        #1 rst = 1'b1;
        #1;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++;
            $display("FAIL reset_req: got %b want 0", imem_req); end
        n_checks++; if (ifid_valid !== 1'b0) begin n_fail++;
            $display("FAIL reset_valid: got %b want 0", ifid_valid); end
        n_checks++; if (ifid_instr !== 32'h0) begin n_fail++;
            $display("FAIL reset_instr: got %h want 0", ifid_instr); end
        n_checks++; if (ifid_pc4 !== 32'h0) begin n_fail++;
            $display("FAIL reset_pc4: got %h want 0", ifid_pc4); end
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        #1;
        n_checks++; if (imem_req !== 1'b1) begin n_fail++;
            $display("FAIL first_req: got %b want 1", imem_req); end
        n_checks++; if (imem_addr !== 32'h0) begin n_fail++;
            $display("FAIL first_addr: got %h want 0", imem_addr); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_stream;
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, 0, 32'h0, 1);
            n_checks++; if (imem_addr !== 32'(4 * i)) begin n_fail++;
                $display("FAIL stream_addr[%0d]: got %h want %h", i, imem_addr, 4 * i); end
            advance();
            n_checks++; if (ifid_pc4 !== 32'(4 * i + 4)) begin n_fail++;
                $display("FAIL stream_pc4[%0d]: got %h want %h", i, ifid_pc4, 4 * i + 4); end
            n_checks++; if (ifid_instr !== mem_word(32'(4 * i)) || ifid_valid !== 1'b1) begin
                n_fail++; $display("FAIL stream_instr[%0d]: got %h/%b want %h/1", i,
                                   ifid_instr, ifid_valid, mem_word(32'(4 * i))); end
        end
    endtask

    task automatic test_stall;
        drive(0, 0, 0, 0, 32'h0, 1);
        n_checks++; if (imem_addr !== 32'h10) begin n_fail++;
            $display("FAIL stall_addr: got %h want 10", imem_addr); end
        advance();
        n_checks++; if (ifid_pc4 !== 32'h10 || ifid_instr !== mem_word(32'hC)) begin n_fail++;
            $display("FAIL stall_ifid_hold: got %h/%h want 10/%h", ifid_pc4, ifid_instr,
                     mem_word(32'hC)); end
        n_checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h10) begin n_fail++;
            $display("FAIL stall_pc_hold: got req %b addr %h want 0/10", imem_req, imem_addr); end
        drive(1, 1, 0, 0, 32'h0, 0);
        advance();
        n_checks++; if (ifid_pc4 !== 32'h14 || ifid_instr !== mem_word(32'h10)) begin
            n_fail++; $display("FAIL stall_release: got %h/%h want 14/%h", ifid_pc4,
                               ifid_instr, mem_word(32'h10)); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin n_fail++;
            $display("FAIL stall_next_req: got %b/%h want 1/14", imem_req, imem_addr); end
        drive(1, 1, 0, 0, 32'h0, 1);
        advance();
        n_checks++; if (ifid_pc4 !== 32'h18 || ifid_valid !== 1'b1) begin n_fail++;
            $display("FAIL stall_resume: got %h/%b want 18/1", ifid_pc4, ifid_valid); end
    endtask

    task automatic test_latency;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 0, 0, 32'h0, k == 2);
            n_checks++; if (if_busy !== (k != 2) || imem_addr !== 32'h0) begin n_fail++;
                $display("FAIL lat_busy[%0d]: got %b/%h want %b/0", k, if_busy, imem_addr,
                         k != 2); end
            advance();
            if (k < 2) begin
                n_checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin n_fail++;
                    $display("FAIL lat_bubble[%0d]: got %b/%h want 0/0", k, ifid_valid,
                             ifid_instr); end
            end else begin
                n_checks++; if (ifid_valid !== 1'b1 || ifid_pc4 !== 32'h4 ||
                                ifid_instr !== mem_word(32'h0)) begin n_fail++;
                    $display("FAIL lat_enter: got %b/%h/%h want 1/4/%h", ifid_valid, ifid_pc4,
                             ifid_instr, mem_word(32'h0)); end
            end
        end
    endtask

    task automatic test_hold;
        drive(0, 0, 0, 0, 32'h0, 0);
        n_checks++; if (if_busy !== 1'b1) begin n_fail++;
            $display("FAIL hold_busy: got %b want 1", if_busy); end
        advance();
        drive(0, 0, 0, 0, 32'h0, 1);
        advance();
        n_checks++; if (imem_req !== 1'b0) begin n_fail++;
            $display("FAIL hold_req: got %b want 0", imem_req); end
        n_checks++; if (ifid_pc4 !== 32'h4 || ifid_valid !== 1'b1) begin n_fail++;
            $display("FAIL hold_ifid: got %h/%b want 4/1", ifid_pc4, ifid_valid); end
        drive(0, 0, 0, 0, 32'h0, 0);
        n_checks++; if (if_busy !== 1'b0) begin n_fail++;
            $display("FAIL hold_idle_busy: got %b want 0", if_busy); end
        advance();
        drive(1, 1, 0, 0, 32'h0, 0);
        advance();
        n_checks++; if (ifid_pc4 !== 32'h8 || ifid_instr !== mem_word(32'h4)) begin n_fail++;
            $display("FAIL hold_deliver: got %h/%h want 8/%h", ifid_pc4, ifid_instr,
                     mem_word(32'h4)); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin n_fail++;
            $display("FAIL hold_next_req: got %b/%h want 1/8", imem_req, imem_addr); end
    endtask

    task automatic test_redirect;
        drive(1, 1, 0, 1, 32'h40, 0);
        advance();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin n_fail++;
            $display("FAIL redir_drop_addr: got %b/%h want 1/8", imem_req, imem_addr); end
        n_checks++; if (ifid_valid !== 1'b0) begin n_fail++;
            $display("FAIL redir_bubble: got %b want 0", ifid_valid); end
        drive(1, 1, 0, 0, 32'h0, 1);
        advance();
        n_checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin n_fail++;
            $display("FAIL redir_discard: got %b/%h want 0/0", ifid_valid, ifid_instr); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin n_fail++;
            $display("FAIL redir_target: got %b/%h want 1/40", imem_req, imem_addr); end
        drive(1, 1, 0, 0, 32'h0, 1);
        advance();
        n_checks++; if (ifid_pc4 !== 32'h44 || ifid_instr !== mem_word(32'h40)) begin
            n_fail++; $display("FAIL redir_enter: got %h/%h want 44/%h", ifid_pc4, ifid_instr,
                               mem_word(32'h40)); end
    endtask

    task automatic test_flush_ack;
        drive(1, 1, 1, 0, 32'h0, 1);
        advance();
        n_checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0 || ifid_pc4 !== 32'h44)
            begin n_fail++; $display("FAIL flush_bubble: got %b/%h/%h want 0/0/44",
                                     ifid_valid, ifid_instr, ifid_pc4); end
        n_checks++; if (imem_req !== 1'b0) begin n_fail++;
            $display("FAIL flush_buffered: got req %b want 0", imem_req); end
        drive(1, 1, 0, 0, 32'h0, 0);
        advance();
        n_checks++; if (ifid_pc4 !== 32'h48 || ifid_instr !== mem_word(32'h44) ||
                        ifid_valid !== 1'b1) begin n_fail++;
            $display("FAIL flush_deliver: got %h/%h/%b want 48/%h/1", ifid_pc4, ifid_instr,
                     ifid_valid, mem_word(32'h44)); end
        n_checks++; if (imem_addr !== 32'h48) begin n_fail++;
            $display("FAIL flush_next_addr: got %h want 48", imem_addr); end
    endtask

    task automatic test_random;
        do_reset();
        mem_pend = 0;
        for (int c = 0; c < 600; c++) begin
            bit          ack;
            logic [31:0] tgt;
            if (!mem_pend && imem_req) begin
                mem_pend = 1;
                mem_lat  = $urandom_range(0, 3);
            end
            ack = mem_pend && (mem_lat == 0);
            tgt = 32'($urandom_range(0, 255)) << 2;
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0, tgt, ack);
            n_checks++; if (imem_req !== !m_hold) begin n_fail++;
                $display("FAIL rnd_req[%0d]: got %b want %b", c, imem_req, !m_hold); end
            if (!m_hold) begin
                n_checks++; if (imem_addr !== (m_drop ? m_drop_addr : m_pc)) begin n_fail++;
                    $display("FAIL rnd_addr[%0d]: got %h want %h", c, imem_addr,
                             m_drop ? m_drop_addr : m_pc); end
            end
            n_checks++; if (if_busy !== (!m_hold && !ack)) begin n_fail++;
                $display("FAIL rnd_busy[%0d]: got %b want %b", c, if_busy, !m_hold && !ack); end
            advance();
            n_checks++; if (ifid_valid !== m_valid || ifid_instr !== m_instr ||
                            ifid_pc4 !== m_pc4) begin n_fail++;
                $display("FAIL rnd_ifid[%0d]: got %b/%h/%h want %b/%h/%h", c, ifid_valid,
                         ifid_instr, ifid_pc4, m_valid, m_instr, m_pc4); end
            if (ack) mem_pend = 0;
            else if (mem_pend) mem_lat--;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_stall();
        test_latency();
        test_hold();
        test_redirect();
        test_flush_ack();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
